reg_write_scheduler: RTL and testbench

Schedules the CPU's single register-file write port among several writeback sources and tracks pending writes per register. Requesters (ALU, memory load, link/PC) present an address and data with a valid/ready handshake. A round-robin arbiter picks one per cycle and drives a registered write command (`wr_en`, `wr_sel`, `wr_data`) into the register-file decoder and write port. A per-register busy scoreboard lets issue logic reserve a destination and detect hazards until the write commits.

---
 rtl/reg_sched_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 27 ++
 rtl/reg_write_scheduler.sv | 91 +++++++++
 tb/tb_reg_write_scheduler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_sched_pkg.sv
// Shared defaults and requester indices for the register-file write scheduler.
package reg_sched_pkg;
    localparam int DEF_NREQ = 3;
    localparam int DEF_NREG = 8;
    localparam int DEF_AW   = 3;
    localparam int DEF_DW   = 8;

    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
    localparam int REQ_LINK = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward and returns a one-hot grant
// plus the pointer value to load if that grant is accepted.
module rr_arbiter #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   ptr_next
);
    always_comb begin
        int  idx;
        logic found;
        grant    = '0;
        ptr_next = ptr;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = PW'((idx + 1) % NREQ);
            end
        end
    end
endmodule

// File: rtl/reg_write_scheduler.sv
// Arbitrates writeback sources onto the single register-file write port and keeps a
// per-register busy scoreboard for reservations from issue logic.
module reg_write_scheduler
    import reg_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_sel,
    output logic [DW-1:0]        wr_data,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ok,
    output logic [NREG-1:0]      busy,
    output logic                 err_unrsv
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_next;
    logic [NREQ-1:0] grant;
    logic            accept;
    logic [AW-1:0]   acc_addr;
    logic [DW-1:0]   acc_data;
    logic [NREG-1:0] busy_next;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign rsv_ok    = !busy[rsv_addr];

    always_comb begin
        acc_addr = '0;
        acc_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                acc_addr = req_addr[i*AW +: AW];
                acc_data = req_data[i*DW +: DW];
            end
        end
    end

    // Set is ORed in after the clear so an unreserved commit racing a reserve ends busy.
    always_comb begin
        busy_next = '0;
        for (int r = 0; r < NREG; r++) begin
            busy_next[r] = (busy[r] && !(wr_en && wr_sel == AW'(r)))
                         || (rsv_valid && rsv_ok && rsv_addr == AW'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            wr_en     <= 1'b0;
            wr_sel    <= '0;
            wr_data   <= '0;
            busy      <= '0;
            err_unrsv <= 1'b0;
        end else begin
            ptr   <= ptr_next;
            wr_en <= accept;
            if (accept) begin
                wr_sel  <= acc_addr;
                wr_data <= acc_data;
            end
            busy <= busy_next;
            if (wr_en && !busy[wr_sel]) begin
                err_unrsv <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_write_scheduler.sv
// Directed bench: stimulus pushes expected write commands into a queue, a negedge
// monitor pops and compares them whenever wr_en is presented.
module tb_reg_write_scheduler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [8:0]  req_addr = '0;
    logic [23:0] req_data = '0;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        rsv_valid = 1'b0;
    logic [2:0]  rsv_addr = '0;
    logic        rsv_ok;
    logic [7:0]  busy;
    logic        err_unrsv;

    int n_checks = 0;
    int n_pass   = 0;
    logic [10:0] exp_q[$];

    always #5 clk = ~clk;

    reg_write_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ok    (rsv_ok),
        .busy      (busy),
        .err_unrsv (err_unrsv)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got sel=%0d data=%0h expected no write", wr_sel, wr_data);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                if ({wr_sel, wr_data} === e) n_pass++;
                else $display("FAIL wr_cmd: got sel=%0d data=%0h expected sel=%0d data=%0h",
                              wr_sel, wr_data, e[10:8], e[7:0]);
            end
        end
    end

    // Called at posedge+1; drives one cycle of inputs and returns at the next posedge+1.
    task automatic step(input logic [2:0] v, input logic [8:0] a, input logic [23:0] d,
                        input logic rv, input logic [2:0] ra, input logic [2:0] er);
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        rsv_valid = rv;
        rsv_addr  = ra;
        #1;
        chk("req_ready", 32'(req_ready), 32'(er));
        for (int i = 0; i < 3; i++)
            if (er[i]) exp_q.push_back({a[i*3 +: 3], d[i*8 +: 8]});
        @(posedge clk);
        #1;
        req_valid = '0;
        rsv_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_wr_en",   32'(wr_en), 32'd0);
        chk("rst_wr_sel",  32'(wr_sel), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_err",     32'(err_unrsv), 32'd0);
        chk("rst_rsv_ok",  32'(rsv_ok), 32'd1);
        chk("rst_ready",   32'(req_ready), 32'd0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsv_valid = 1'b0;
        exp_q.delete();
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] ALU  = 3'b001;
    localparam logic [2:0] MEM  = 3'b010;
    localparam logic [2:0] LINK = 3'b100;

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Reservations r3 then r5, then a rejected repeat of r3.
        step(NONE, '0, '0, 1'b1, 3'd3, NONE);
        chk("busy_r3", 32'(busy), 32'h08);
        step(NONE, '0, '0, 1'b1, 3'd5, NONE);
        chk("busy_r3_r5", 32'(busy), 32'h28);
        rsv_addr = 3'd3;
        #1;
        chk("rsv_ok_r3_taken", 32'(rsv_ok), 32'd0);
        #0;
        step(NONE, '0, '0, 1'b1, 3'd3, NONE);
        chk("busy_unchanged", 32'(busy), 32'h28);

        // LINK alone from ptr 0 wins at once and wraps ptr to 0; ALU then beats LINK.
        step(LINK, {3'd5, 3'd0, 3'd0}, {8'h5C, 8'h00, 8'h00}, 1'b0, 3'd0, LINK);
        chk("link_wr_sel", 32'(wr_sel), 32'd5);
        step(ALU | LINK, {3'd5, 3'd0, 3'd3}, {8'h77, 8'h00, 8'h3A}, 1'b0, 3'd0, ALU);
        chk("busy_after_link", 32'(busy), 32'h08);
        chk("alu_wr_sel", 32'(wr_sel), 32'd3);

        // Reserved MEM write of r4.
        step(NONE, '0, '0, 1'b1, 3'd4, NONE);
        chk("busy_r4", 32'(busy), 32'h10);
        step(MEM, {3'd0, 3'd4, 3'd0}, {8'h00, 8'hA5, 8'h00}, 1'b0, 3'd0, MEM);
        chk("mem_wr_en", 32'(wr_en), 32'd1);
        chk("mem_wr_sel", 32'(wr_sel), 32'd4);
        chk("mem_wr_data", 32'(wr_data), 32'hA5);
        chk("mem_busy_still", 32'(busy[4]), 32'd1);
        step(NONE, '0, '0, 1'b0, 3'd0, NONE);
        chk("mem_busy_clear", 32'(busy[4]), 32'd0);
        chk("mem_wr_en_drop", 32'(wr_en), 32'd0);
        chk("mem_wr_sel_hold", 32'(wr_sel), 32'd4);
        chk("mem_err", 32'(err_unrsv), 32'd0);

        // Rotation with all three valid from ptr 0.
        do_reset();
        step(3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'd0, ALU);
        chk("rot_sel0", 32'(wr_sel), 32'd1);
        step(3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'd0, MEM);
        chk("rot_sel1", 32'(wr_sel), 32'd2);
        step(3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'd0, LINK);
        chk("rot_sel2", 32'(wr_sel), 32'd3);
        step(3'b111, {3'd3, 3'd2, 3'd1}, {8'h33, 8'h22, 8'h11}, 1'b0, 3'd0, ALU);
        chk("rot_sel3", 32'(wr_sel), 32'd1);
        chk("rot_err", 32'(err_unrsv), 32'd1);

        // Unreserved ALU write of r6 racing a reserve of r6 in the commit cycle.
        do_reset();
        step(ALU, {3'd0, 3'd0, 3'd6}, {8'h00, 8'h00, 8'h66}, 1'b0, 3'd0, ALU);
        chk("race_err_before", 32'(err_unrsv), 32'd0);
        step(NONE, '0, '0, 1'b1, 3'd6, NONE);
        chk("race_err", 32'(err_unrsv), 32'd1);
        chk("race_busy", 32'(busy), 32'h40);

        // Fill the scoreboard, leave a write in flight, then reset between edges.
        do_reset();
        for (int r = 0; r < 7; r++)
            step(NONE, '0, '0, 1'b1, 3'(r), NONE);
        step(ALU, {3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'hEE}, 1'b1, 3'd7, ALU);
        chk("pre_rst_busy", 32'(busy), 32'hFF);
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        do_reset();
        step(NONE, '0, '0, 1'b0, 3'd0, NONE);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
